// File: rtl/cache_arbiter2.sv
// Two-client round-robin arbiter in front of a single-cycle cache port.
// Tracks the one outstanding response and routes it only to its owner.
module cache_arbiter2 #(
   parameter int REQ_W  = 70,
   parameter int RESP_W = 52
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              req0_put_valid,
   output logic              req0_put_ready,
   input  logic [REQ_W-1:0]  req0_put_request,
   input  logic              req0_get_valid,
   output logic              req0_get_ready,
   output logic [RESP_W-1:0] req0_get_response,
   input  logic              req1_put_valid,
   output logic              req1_put_ready,
   input  logic [REQ_W-1:0]  req1_put_request,
   input  logic              req1_get_valid,
   output logic              req1_get_ready,
   output logic [RESP_W-1:0] req1_get_response,
   output logic              cache_put_valid,
   input  logic              cache_put_ready,
   output logic [REQ_W-1:0]  cache_put_request,
   output logic              cache_get_valid,
   input  logic              cache_get_ready,
   input  logic [RESP_W-1:0] cache_get_response
);

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   state_t state_q, state_d;
   logic   owner_q, owner_d;
   logic   rr_q, rr_d;

   logic   grant;
   logic   owner_get_valid;
   logic   get_fire;
   logic   put_enable;
   logic   put_fire;

   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
      grant = rr_q;
      if (req0_put_valid && !req1_put_valid) grant = 1'b0;
      else if (!req0_put_valid && req1_put_valid) grant = 1'b1;

      owner_get_valid = owner_q ? req1_get_valid : req0_get_valid;
      get_fire        = (state_q == BUSY) && owner_get_valid && cache_get_ready;
      // A completing response frees the port for a new request in the same cycle.
      put_enable      = (state_q == IDLE) || get_fire;

      cache_put_request = grant ? req1_put_request : req0_put_request;
      cache_put_valid   = RST_N && put_enable && (req0_put_valid || req1_put_valid);
      put_fire          = cache_put_valid && cache_put_ready;

      req0_put_ready = RST_N && put_enable && cache_put_ready && !grant;
      req1_put_ready = RST_N && put_enable && cache_put_ready && grant;

      cache_get_valid   = RST_N && (state_q == BUSY) && owner_get_valid;
      req0_get_ready    = RST_N && (state_q == BUSY) && !owner_q && cache_get_ready;
      req1_get_ready    = RST_N && (state_q == BUSY) && owner_q && cache_get_ready;
      req0_get_response = cache_get_response;
      req1_get_response = cache_get_response;

      state_d = state_q;
      owner_d = owner_q;
      rr_d    = rr_q;
      if (put_fire) begin
         rr_d = ~grant;
         if (!cache_put_request[0]) begin
            state_d = BUSY;
            owner_d = grant;
         end else begin
            state_d = IDLE;
         end
      end else if (get_fire) begin
         state_d = IDLE;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q <= IDLE;
         owner_q <= 1'b0;
         rr_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         rr_q    <= rr_d;
      end
   end

endmodule

// File: tb/tb_cache_arbiter2.sv
// Directed self-checking bench for cache_arbiter2: reset, single load,
// store bypass, round-robin fairness, owner stall and mid-operation reset.
module tb_cache_arbiter2;

   localparam int REQ_W  = 70;
   localparam int RESP_W = 52;

   logic              CLK;
   logic              RST_N;
   logic              req0_put_valid, req0_put_ready, req0_get_valid, req0_get_ready;
   logic              req1_put_valid, req1_put_ready, req1_get_valid, req1_get_ready;
   logic [REQ_W-1:0]  req0_put_request, req1_put_request, cache_put_request;
   logic [RESP_W-1:0] req0_get_response, req1_get_response, cache_get_response;
   logic              cache_put_valid, cache_put_ready, cache_get_valid, cache_get_ready;

   int checks = 0;
   int errors = 0;

   cache_arbiter2 #(.REQ_W(REQ_W), .RESP_W(RESP_W)) dut (
      .CLK                (CLK),
      .RST_N              (RST_N),
      .req0_put_valid     (req0_put_valid),
      .req0_put_ready     (req0_put_ready),
      .req0_put_request   (req0_put_request),
      .req0_get_valid     (req0_get_valid),
      .req0_get_ready     (req0_get_ready),
      .req0_get_response  (req0_get_response),
      .req1_put_valid     (req1_put_valid),
      .req1_put_ready     (req1_put_ready),
      .req1_put_request   (req1_put_request),
      .req1_get_valid     (req1_get_valid),
      .req1_get_ready     (req1_get_ready),
      .req1_get_response  (req1_get_response),
      .cache_put_valid    (cache_put_valid),
      .cache_put_ready    (cache_put_ready),
      .cache_put_request  (cache_put_request),
      .cache_get_valid    (cache_get_valid),
      .cache_get_ready    (cache_get_ready),
      .cache_get_response (cache_get_response)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one cycle; inputs are then driven 2 time units after the edge
   // and outputs sampled 1 unit later, well away from the next edge.
   task automatic tick();
      @(posedge CLK);
      #2;
   endtask

   task automatic idle_inputs();
      req0_put_valid     = 1'b0;
      req1_put_valid     = 1'b0;
      req0_get_valid     = 1'b0;
      req1_get_valid     = 1'b0;
      cache_put_ready    = 1'b0;
      cache_get_ready    = 1'b0;
      req0_put_request   = '0;
      req1_put_request   = '0;
      cache_get_response = '0;
   endtask

   logic [REQ_W-1:0]  ld_a, ld_b, ld_p0, ld_p1, st_s;
   logic [RESP_W-1:0] rsp_1, rsp_2, rsp_a, rsp_b, rsp_c, rsp_d;

   initial begin
      ld_a  = {4'hF, 65'h0_1234_5678_9ABC_DEF0, 1'b0};
      ld_b  = {4'h3, 65'h1_0000_0000_CAFE_BABE, 1'b0};
      ld_p0 = {4'hA, 65'h0_0000_0000_0000_1000, 1'b0};
      ld_p1 = {4'h5, 65'h0_0000_0000_0000_2000, 1'b0};
      st_s  = {4'hC, 65'h0_DEAD_BEEF_0000_0001, 1'b1};
      rsp_1 = 52'hA_BCDE_F012_3456;
      rsp_2 = 52'h1_1111_2222_3333;
      rsp_a = 52'h0_0000_0000_00AA;
      rsp_b = 52'h0_0000_0000_00BB;
      rsp_c = 52'h0_0000_0000_00CC;
      rsp_d = 52'h0_0000_0000_00DD;

      // Reset: outputs forced low even with every input asserted.
      RST_N = 1'b0;
      idle_inputs();
      req0_put_valid  = 1'b1;
      req0_get_valid  = 1'b1;
      cache_put_ready = 1'b1;
      cache_get_ready = 1'b1;
      #3;
      check("rst_req0_put_ready", req0_put_ready, 0);
      check("rst_cache_put_valid", cache_put_valid, 0);
      check("rst_cache_get_valid", cache_get_valid, 0);
      check("rst_req0_get_ready", req0_get_ready, 0);
      tick();
      tick();
      RST_N = 1'b1;
      idle_inputs();

      // Single load by req0: accepted at t0, response at t1, IDLE at t2.
      req0_put_valid   = 1'b1;
      req0_put_request = ld_a;
      cache_put_ready  = 1'b1;
      #1;
      check("t0_req0_put_ready", req0_put_ready, 1);
      check("t0_req1_put_ready", req1_put_ready, 0);
      check("t0_cache_put_valid", cache_put_valid, 1);
      check("t0_cache_put_request", cache_put_request, ld_a);
      check("t0_cache_get_valid", cache_get_valid, 0);
      tick();
      idle_inputs();
      req0_get_valid     = 1'b1;
      cache_get_ready    = 1'b1;
      cache_get_response = rsp_1;
      #1;
      check("t1_req0_get_ready", req0_get_ready, 1);
      check("t1_req1_get_ready", req1_get_ready, 0);
      check("t1_req0_get_response", req0_get_response, rsp_1);
      check("t1_cache_get_valid", cache_get_valid, 1);
      tick();
      #1;
      check("t2_req0_get_ready_idle", req0_get_ready, 0);
      check("t2_cache_get_valid_idle", cache_get_valid, 0);
      tick();

      // Store by req1 (rr=1 now), then req0 load next cycle.
      idle_inputs();
      req1_put_valid   = 1'b1;
      req1_put_request = st_s;
      cache_put_ready  = 1'b1;
      #1;
      check("st_req1_put_ready", req1_put_ready, 1);
      check("st_cache_put_request", cache_put_request, st_s);
      tick();
      idle_inputs();
      req0_put_valid   = 1'b1;
      req0_put_request = ld_b;
      req1_get_valid   = 1'b1;
      cache_put_ready  = 1'b1;
      cache_get_ready  = 1'b1;
      #1;
      check("st_no_owner_req1_get_ready", req1_get_ready, 0);
      check("st_follow_req0_put_ready", req0_put_ready, 1);
      check("st_follow_cache_put_request", cache_put_request, ld_b);
      tick();
      // Response to req0 while req1 issues another store in the same cycle.
      idle_inputs();
      req0_get_valid     = 1'b1;
      req1_get_valid     = 1'b1;
      req1_put_valid     = 1'b1;
      req1_put_request   = st_s;
      cache_put_ready    = 1'b1;
      cache_get_ready    = 1'b1;
      cache_get_response = rsp_2;
      #1;
      check("mix_req0_get_ready", req0_get_ready, 1);
      check("mix_req1_get_ready", req1_get_ready, 0);
      check("mix_req0_get_response", req0_get_response, rsp_2);
      check("mix_req1_put_ready", req1_put_ready, 1);
      tick();

      // Fairness: both valid, loads every cycle, owners always take responses.
      idle_inputs();
      req0_put_valid   = 1'b1;
      req1_put_valid   = 1'b1;
      req0_put_request = ld_p0;
      req1_put_request = ld_p1;
      req0_get_valid   = 1'b1;
      req1_get_valid   = 1'b1;
      cache_put_ready  = 1'b1;
      cache_get_ready  = 1'b1;
      #1;
      check("rr0_req0_put_ready", req0_put_ready, 1);
      check("rr0_req1_put_ready", req1_put_ready, 0);
      check("rr0_req1_get_ready_idle", req1_get_ready, 0);
      check("rr0_cache_put_request", cache_put_request, ld_p0);
      tick();
      cache_get_response = rsp_a;
      #1;
      check("rr1_req0_get_ready", req0_get_ready, 1);
      check("rr1_req1_get_ready", req1_get_ready, 0);
      check("rr1_req1_put_ready", req1_put_ready, 1);
      check("rr1_req0_put_ready", req0_put_ready, 0);
      check("rr1_cache_put_request", cache_put_request, ld_p1);
      tick();
      cache_get_response = rsp_b;
      #1;
      check("rr2_req1_get_ready", req1_get_ready, 1);
      check("rr2_req0_get_ready", req0_get_ready, 0);
      check("rr2_req1_get_response", req1_get_response, rsp_b);
      check("rr2_req0_put_ready", req0_put_ready, 1);
      tick();
      cache_get_response = rsp_c;
      #1;
      check("rr3_req0_get_ready", req0_get_ready, 1);
      check("rr3_req1_get_ready", req1_get_ready, 0);
      check("rr3_req1_put_ready", req1_put_ready, 1);
      tick();
      req0_put_valid     = 1'b0;
      req1_put_valid     = 1'b0;
      cache_get_response = rsp_d;
      #1;
      check("rr4_req1_get_ready", req1_get_ready, 1);
      check("rr4_req0_get_ready", req0_get_ready, 0);
      check("rr4_cache_put_valid", cache_put_valid, 0);
      tick();

      // Owner stall: req0 load outstanding, req0_get_valid low for 5 cycles.
      idle_inputs();
      req0_put_valid   = 1'b1;
      req0_put_request = ld_a;
      cache_put_ready  = 1'b1;
      #1;
      check("stall_accept_req0", req0_put_ready, 1);
      tick();
      idle_inputs();
      req1_put_valid   = 1'b1;
      req1_put_request = ld_b;
      cache_put_ready  = 1'b1;
      cache_get_ready  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         check($sformatf("stall%0d_req1_put_ready", i), req1_put_ready, 0);
         check($sformatf("stall%0d_cache_put_valid", i), cache_put_valid, 0);
         check($sformatf("stall%0d_cache_get_valid", i), cache_get_valid, 0);
         tick();
      end
      req0_get_valid = 1'b1;
      #1;
      check("stall_rel_req0_get_ready", req0_get_ready, 1);
      check("stall_rel_cache_get_valid", cache_get_valid, 1);
      check("stall_rel_req1_put_ready", req1_put_ready, 1);
      check("stall_rel_cache_put_request", cache_put_request, ld_b);
      tick();

      // Reset while BUSY with owner=1: response is dropped, rr restarts at 0.
      idle_inputs();
      RST_N           = 1'b0;
      req1_get_valid  = 1'b1;
      cache_get_ready = 1'b1;
      #1;
      check("mrst_req1_get_ready_in_reset", req1_get_ready, 0);
      tick();
      RST_N = 1'b1;
      #1;
      check("mrst_req1_get_ready_after", req1_get_ready, 0);
      check("mrst_cache_get_valid_after", cache_get_valid, 0);
      req0_put_valid   = 1'b1;
      req1_put_valid   = 1'b1;
      req0_put_request = ld_p0;
      req1_put_request = ld_p1;
      cache_put_ready  = 1'b1;
      #1;
      check("mrst_grant_req0_put_ready", req0_put_ready, 1);
      check("mrst_grant_req1_put_ready", req1_put_ready, 0);
      check("mrst_cache_put_request", cache_put_request, ld_p0);
      tick();
      idle_inputs();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/cache_arbiter2.md
# cache_arbiter2

Two-requester arbiter sharing one single-cycle cache port between two clients (e.g. instruction and data side, or two isolated cores). Accepts put requests from both clients, grants one per cycle by round robin, tracks which client owns the single outstanding response, and returns `get_ready`/response only to that owner. It adds no latency in either direction. Requests flagged "ignore response" (store-only) are forwarded without taking ownership of the response path.

## Interface
- `REQ_W`, 70: request packet width. Bit 0 is `ignore_response`; bits `[REQ_W-1:REQ_W-4]` are byte enables.
- `RESP_W`, 52: response row width.
- `CLK`  in  1  clock.
- `RST_N`  in  1  reset: synchronous, active-low.
- `req0_put_valid`, `req1_put_valid`  in  1  client has a request.
- `req0_put_ready`, `req1_put_ready`  out  1  client request accepted this cycle if also valid.
- `req0_put_request`, `req1_put_request`  in  REQ_W  client request packet.
- `req0_get_valid`, `req1_get_valid`  in  1  client ready to take a response.
- `req0_get_ready`, `req1_get_ready`  out  1  response available to this client.
- `req0_get_response`, `req1_get_response`  out  RESP_W  both driven from `cache_get_response`; meaningful only with the matching `get_ready`.
- `cache_put_valid`  out  1  forwarded request valid.
- `cache_put_ready`  in  1  cache accepts a request.
- `cache_put_request`  out  REQ_W  forwarded packet, muxed by grant.
- `cache_get_valid`  out  1  owner's `get_valid`, forwarded.
- `cache_get_ready`  in  1  cache has a response.
- `cache_get_response`  in  RESP_W  cache response row.

## Operation
- State: `state` ∈ {IDLE, BUSY}, `owner` (1 bit), `rr` (1 bit, the preferred client).
- Grant is combinational:
  - Only one client valid: grant that client.
  - Both valid: grant `rr`.
  - `put_enable` = (state==IDLE) OR (state==BUSY AND owner get handshake fires this cycle).
- Put forwarding:
  - `cache_put_valid` = `put_enable` AND `granted_valid`.
  - `cache_put_request` = packet of the granted client.
  - Granted client's `put_ready` = `put_enable` AND `cache_put_ready`. Non-granted client's `put_ready` = 0.
- Get forwarding:
  - In BUSY: `cache_get_valid` = `reqN_get_valid` of the owner, and the owner's `get_ready` = `cache_get_ready`.
  - In IDLE: `cache_get_valid` = 0 and all `get_ready` = 0.
- Put handshake (`cache_put_valid` AND `cache_put_ready`):
  - `rr` ← the other client.
  - If `ignore_response`=0: next state BUSY, `owner` ← granted client.
  - Else: next state IDLE, unless a get handshake in the same cycle leaves nothing outstanding; result is IDLE.
- Get handshake in BUSY without a new response-bearing put: next state IDLE.
- Simultaneous get and put handshake in BUSY: the response completes and the new request is accepted in the same cycle. Next state follows the new request's `ignore_response` bit.
- A client is never granted while holding an uncompleted response-bearing request. Clients must not drop `put_valid` before `put_ready`.

## Timing
- Reset (RST_N=0 at a CLK edge):
  - `state`=IDLE, `owner`=0, `rr`=0.
  - While RST_N=0, all outputs `*_ready` and `cache_*_valid` are forced to 0.
- Reset mid-operation: any outstanding response is discarded and no `get_ready` reaches either client afterward. The cache is reset on the same RST_N.
- Latency:
  - Zero added cycles; grant, mux and ready are purely combinational.
  - A response-bearing request accepted in cycle t gets its response no earlier than t+1, when the cache asserts `cache_get_ready`.
- Throughput: one request per cycle. Back-to-back response-bearing requests are sustained when the owner asserts `get_valid` in the response cycle.
- Fairness: with both clients continuously valid, grants alternate 0,1,0,1,… Worst-case wait is one accepted request of the other client plus its response.
- Stalls:
  - `cache_put_ready`=0 holds the grant and `rr` unchanged.
  - Owner `get_valid`=0 holds BUSY indefinitely and blocks both clients' puts.

## Test plan
- Reset, then `req0` load (`ignore_response`=0) at t0 with `cache_put_ready`=1 → `req0_put_ready`=1 at t0. At t1, `req0_get_ready`=1, `req1_get_ready`=0, and `req0_get_response` equals the cache row. Back to IDLE at t2.
- Both clients valid with loads every cycle, owners always `get_valid` → grant order 0,1,0,1, one accept per cycle, and each response reaches only the client that issued it.
- `req1` store with `ignore_response`=1, followed by a `req0` load the next cycle → the store takes no ownership, the `req0` load is accepted one cycle later, and `req1_get_ready` never asserts.
- `req0` load outstanding with `req0_get_valid`=0 for 5 cycles and `req1_put_valid`=1 → `req1_put_ready`=0 for all 5 cycles. After `req0` completes, `req1` is accepted in the same cycle as the get handshake.
- RST_N low for one cycle while BUSY with owner=1 → on the following cycles `state`=IDLE and `req1_get_ready`=0. The first new request is granted with `rr`=0 priority.
